// File: rtl/gmii_pkg.sv
// Shared types and encodings for the GMII receive demultiplexer.
// Route vectors are {out1, out0}: bit 1 enables output 1, bit 0 enables output 0.
package gmii_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] rxd;
    logic       dv;
    logic       er;
  } gmii_t;

  localparam logic [1:0] SEL_OUT1 = 2'b00;
  localparam logic [1:0] SEL_OUT0 = 2'b01;
  localparam logic [1:0] SEL_BOTH = 2'b10;  // bit 1 set means tee, bit 0 is don't-care

  localparam logic [1:0] ROUTE_OUT0 = 2'b01;
  localparam logic [1:0] ROUTE_OUT1 = 2'b10;
  localparam logic [1:0] ROUTE_BOTH = 2'b11;

  localparam gmii_t GMII_IDLE = '{rxd: 8'h00, dv: 1'b0, er: 1'b0};

  function automatic logic [1:0] route_decode(input logic [1:0] sel);
    logic [1:0] r;
    if ((sel & SEL_BOTH) != 2'b00) r = ROUTE_BOTH;
    else if (sel == SEL_OUT0)      r = ROUTE_OUT0;
    else                           r = ROUTE_OUT1;
    return r;
  endfunction

endpackage

// File: rtl/gmii_frame_counter.sv
// Wrapping event counter with asynchronous active-low reset.
module gmii_frame_counter #(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_inc,
  output logic [C_CNT_WIDTH-1:0] o_cnt
);

  logic [C_CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + C_CNT_WIDTH'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/gmii_rx_demux.sv
// Frame-aware GMII RX steering to output 0, output 1 or both; the route only
// changes between frames. Per-output frame counters plus an errored-frame counter.
module gmii_rx_demux
  import gmii_pkg::*;
#(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   gtx_clk,
  input  logic                   gtx_resetn,
  input  logic [1:0]             select,
  input  logic [7:0]             gmii_in_rxd,
  input  logic                   gmii_in_rx_dv,
  input  logic                   gmii_in_rx_er,
  output logic [7:0]             gmii_out_0_rxd,
  output logic                   gmii_out_0_rx_dv,
  output logic                   gmii_out_0_rx_er,
  output logic [7:0]             gmii_out_1_rxd,
  output logic                   gmii_out_1_rx_dv,
  output logic                   gmii_out_1_rx_er,
  output logic                   frame_active,
  output logic [1:0]             route,
  output logic [C_CNT_WIDTH-1:0] frame_cnt_0,
  output logic [C_CNT_WIDTH-1:0] frame_cnt_1,
  output logic [C_CNT_WIDTH-1:0] err_cnt
);

  state_t     r_state;
  logic [1:0] r_route;
  logic       r_err_seen;
  gmii_t      r_out0;
  gmii_t      r_out1;

  gmii_t      w_in;
  logic [1:0] w_dec;
  logic [1:0] w_route_now;
  logic       w_frame_end;

  assign w_in        = '{rxd: gmii_in_rxd, dv: gmii_in_rx_dv, er: gmii_in_rx_er};
  assign w_dec       = route_decode(select);
  // While idle the live select steers traffic; inside a frame the latched route does.
  assign w_route_now = (r_state == ST_IDLE) ? w_dec : r_route;
  assign w_frame_end = (r_state == ST_FRAME) && !gmii_in_rx_dv;

  always_ff @(posedge gtx_clk or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      r_state    <= ST_IDLE;
      r_route    <= ROUTE_OUT1;
      r_err_seen <= 1'b0;
      r_out0     <= GMII_IDLE;
      r_out1     <= GMII_IDLE;
    end else begin
      r_out0 <= w_route_now[0] ? w_in : GMII_IDLE;
      r_out1 <= w_route_now[1] ? w_in : GMII_IDLE;
      case (r_state)
        ST_IDLE: begin
          r_route    <= w_dec;
          r_err_seen <= gmii_in_rx_er;
          if (gmii_in_rx_dv) r_state <= ST_FRAME;
        end
        default: begin
          if (gmii_in_rx_dv) r_err_seen <= r_err_seen | gmii_in_rx_er;
          else               r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  gmii_frame_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_cnt_0 (
    .i_clk   (gtx_clk),
    .i_rst_n (gtx_resetn),
    .i_inc   (w_frame_end && r_route[0]),
    .o_cnt   (frame_cnt_0)
  );

  gmii_frame_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_cnt_1 (
    .i_clk   (gtx_clk),
    .i_rst_n (gtx_resetn),
    .i_inc   (w_frame_end && r_route[1]),
    .o_cnt   (frame_cnt_1)
  );

  gmii_frame_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_cnt_err (
    .i_clk   (gtx_clk),
    .i_rst_n (gtx_resetn),
    .i_inc   (w_frame_end && r_err_seen),
    .o_cnt   (err_cnt)
  );

  assign gmii_out_0_rxd   = r_out0.rxd;
  assign gmii_out_0_rx_dv = r_out0.dv;
  assign gmii_out_0_rx_er = r_out0.er;
  assign gmii_out_1_rxd   = r_out1.rxd;
  assign gmii_out_1_rx_dv = r_out1.dv;
  assign gmii_out_1_rx_er = r_out1.er;
  assign frame_active     = (r_state == ST_FRAME);
  assign route            = r_route;

endmodule
